mem_ctrl: RTL and testbench

- Memory controller between the byte-wide RAM/IO bus and the two memory clients.
- Instruction-fetch cache client: responder for block fetches; accepts a one-cycle query pulse, reads 16 consecutive bytes, returns one 128-bit block with a one-cycle valid pulse.
- Load/store client: byte/half/word reads and writes.
- Single FSM with pending-request latches; the load/store side has priority.

---
 rtl/mem_ctrl_pkg.sv | 29 ++
 rtl/mem_ctrl_if.sv | 38 +++
 rtl/mem_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory controller: state encoding,
// load/store size codes, block geometry and the IO-region tag.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IC_READ  = 2'd1,
        LS_READ  = 2'd2,
        LS_WRITE = 2'd3
    } state_t;

    localparam int         BLOCK_WIDTH  = 2;
    localparam int         BLOCK_BYTES  = 4 << BLOCK_WIDTH;
    localparam logic [1:0] LS_SIZE_BYTE = 2'd0;
    localparam logic [1:0] LS_SIZE_HALF = 2'd1;
    localparam logic [1:0] LS_SIZE_WORD = 2'd2;
    localparam logic [1:0] IO_ADDR_HI   = 2'b11;

    // Size 3 is illegal and is served as a word.
    function automatic logic [4:0] size_bytes(input logic [1:0] size);
        case (size)
            LS_SIZE_BYTE: return 5'd1;
            LS_SIZE_HALF: return 5'd2;
            LS_SIZE_WORD: return 5'd4;
            default:      return 5'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of the RAM/IO bus plus the instruction-cache and load/store client
// signals; slave is the controller side, master is the environment side.
interface mem_ctrl_if;
    logic [7:0]   mem_din;
    logic [7:0]   mem_dout;
    logic [31:0]  mem_a;
    logic         mem_wr;
    logic         io_buffer_full;
    logic         IC_query_en;
    logic [31:0]  IC_query_addr;
    logic         IC_data_en;
    logic [127:0] IC_data;
    logic         LS_query_en;
    logic         LS_wr;
    logic [1:0]   LS_size;
    logic [31:0]  LS_addr;
    logic [31:0]  LS_wdata;
    logic         LS_done;
    logic [31:0]  LS_rdata;

    modport slave (
        input  mem_din, io_buffer_full,
        input  IC_query_en, IC_query_addr,
        input  LS_query_en, LS_wr, LS_size, LS_addr, LS_wdata,
        output mem_dout, mem_a, mem_wr,
        output IC_data_en, IC_data,
        output LS_done, LS_rdata
    );

    modport master (
        output mem_din, io_buffer_full,
        output IC_query_en, IC_query_addr,
        output LS_query_en, LS_wr, LS_size, LS_addr, LS_wdata,
        input  mem_dout, mem_a, mem_wr,
        input  IC_data_en, IC_data,
        input  LS_done, LS_rdata
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-wide memory controller serving 16-byte instruction block fetches and
// byte/half/word load/store requests, load/store side first.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    mem_ctrl_if.slave bus
);

    state_t       state_r, state_n;
    logic [4:0]   k_r, k_n, k_inc_s, n_s;
    logic [31:0]  base_s;
    logic         io_s;
    logic         ic_pend_r, ic_pend_n, ls_pend_r, ls_pend_n;
    logic [31:0]  ic_base_r, ic_base_n;
    logic [31:0]  ls_addr_r, ls_addr_n, ls_wdata_r, ls_wdata_n;
    logic [1:0]   ls_size_r, ls_size_n;
    logic         ls_wr_r, ls_wr_n;
    logic [127:0] ic_buf_r, ic_buf_n, ic_data_r, ic_data_n;
    logic [31:0]  ls_buf_r, ls_buf_n, ls_rdata_r, ls_rdata_n;
    logic [31:0]  mem_a_r, mem_a_n;
    logic [7:0]   mem_dout_r, mem_dout_n;
    logic         mem_wr_r, mem_wr_n;
    logic         ic_data_en_r, ic_data_en_n, ls_done_r, ls_done_n;

    assign k_inc_s = k_r + 5'd1;
    assign n_s     = (state_r == IC_READ) ? 5'(BLOCK_BYTES) : size_bytes(ls_size_r);
    assign base_s  = (state_r == IC_READ) ? ic_base_r : ls_addr_r;
    assign io_s    = (ls_addr_r[17:16] == IO_ADDR_HI);

    assign bus.mem_a      = mem_a_r;
    assign bus.mem_dout   = mem_dout_r;
    assign bus.mem_wr     = mem_wr_r & rdy_in;
    assign bus.IC_data_en = ic_data_en_r;
    assign bus.IC_data    = ic_data_r;
    assign bus.LS_done    = ls_done_r;
    assign bus.LS_rdata   = ls_rdata_r;

    // Request latching, arbitration, byte sequencing and data assembly.
    always_comb begin
        state_n      = state_r;
        k_n          = k_r;
        ic_pend_n    = ic_pend_r;
        ic_base_n    = ic_base_r;
        ls_pend_n    = ls_pend_r;
        ls_addr_n    = ls_addr_r;
        ls_size_n    = ls_size_r;
        ls_wr_n      = ls_wr_r;
        ls_wdata_n   = ls_wdata_r;
        ic_buf_n     = ic_buf_r;
        ic_data_n    = ic_data_r;
        ls_buf_n     = ls_buf_r;
        ls_rdata_n   = ls_rdata_r;
        mem_a_n      = mem_a_r;
        mem_dout_n   = mem_dout_r;
        mem_wr_n     = 1'b0;
        ic_data_en_n = 1'b0;
        ls_done_n    = 1'b0;

        if (bus.IC_query_en) begin
            ic_pend_n = 1'b1;
            ic_base_n = bus.IC_query_addr & 32'hFFFF_FFF0;
        end else begin
            ic_pend_n = ic_pend_r;
        end

        if (bus.LS_query_en) begin
            ls_pend_n  = 1'b1;
            ls_addr_n  = bus.LS_addr;
            ls_size_n  = bus.LS_size;
            ls_wr_n    = bus.LS_wr;
            ls_wdata_n = bus.LS_wdata;
        end else begin
            ls_pend_n = ls_pend_r;
        end

        case (state_r)
            IDLE: begin
                k_n = 5'd0;
                // The _n request fields already merge a same-edge pulse.
                if (ls_pend_n) begin
                    state_n  = ls_wr_n ? LS_WRITE : LS_READ;
                    mem_a_n  = ls_addr_n;
                    ls_buf_n = 32'd0;
                end else if (ic_pend_n) begin
                    state_n = IC_READ;
                    mem_a_n = ic_base_n;
                end else begin
                    state_n = IDLE;
                end
            end
            IC_READ, LS_READ: begin
                if (k_r < n_s) begin
                    if (state_r == IC_READ) begin
                        ic_buf_n[{k_r[3:0], 3'b000} +: 8] = bus.mem_din;
                    end else begin
                        ls_buf_n[{k_r[1:0], 3'b000} +: 8] = bus.mem_din;
                    end
                    if (k_inc_s < n_s) begin
                        mem_a_n = base_s + {27'd0, k_inc_s};
                    end else begin
                        mem_a_n = mem_a_r;
                    end
                    k_n = k_inc_s;
                end else begin
                    if (state_r == IC_READ) begin
                        ic_data_en_n = 1'b1;
                        ic_data_n    = ic_buf_r;
                        ic_pend_n    = bus.IC_query_en;
                    end else begin
                        ls_done_n  = 1'b1;
                        ls_rdata_n = ls_buf_r;
                        ls_pend_n  = bus.LS_query_en;
                    end
                    state_n = IDLE;
                    mem_a_n = 32'd0;
                    k_n     = 5'd0;
                end
            end
            LS_WRITE: begin
                if (k_r < n_s) begin
                    // A full IO sink stalls the byte without consuming it.
                    if (io_s && bus.io_buffer_full) begin
                        mem_wr_n = 1'b0;
                    end else begin
                        mem_wr_n   = 1'b1;
                        mem_a_n    = ls_addr_r + {27'd0, k_r};
                        mem_dout_n = ls_wdata_r[{k_r[1:0], 3'b000} +: 8];
                        k_n        = k_inc_s;
                    end
                end else begin
                    ls_done_n = 1'b1;
                    ls_pend_n = bus.LS_query_en;
                    state_n   = IDLE;
                    mem_a_n   = 32'd0;
                    k_n       = 5'd0;
                end
            end
            default: begin
                state_n = IDLE;
                k_n     = 5'd0;
                mem_a_n = 32'd0;
            end
        endcase
    end

    // State and datapath registers; frozen while rdy_in is low.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r      <= IDLE;
            k_r          <= 5'd0;
            ic_pend_r    <= 1'b0;
            ic_base_r    <= 32'd0;
            ls_pend_r    <= 1'b0;
            ls_addr_r    <= 32'd0;
            ls_size_r    <= 2'd0;
            ls_wr_r      <= 1'b0;
            ls_wdata_r   <= 32'd0;
            ic_buf_r     <= 128'd0;
            ic_data_r    <= 128'd0;
            ls_buf_r     <= 32'd0;
            ls_rdata_r   <= 32'd0;
            mem_a_r      <= 32'd0;
            mem_dout_r   <= 8'd0;
            mem_wr_r     <= 1'b0;
            ic_data_en_r <= 1'b0;
            ls_done_r    <= 1'b0;
        end else if (rdy_in) begin
            state_r      <= state_n;
            k_r          <= k_n;
            ic_pend_r    <= ic_pend_n;
            ic_base_r    <= ic_base_n;
            ls_pend_r    <= ls_pend_n;
            ls_addr_r    <= ls_addr_n;
            ls_size_r    <= ls_size_n;
            ls_wr_r      <= ls_wr_n;
            ls_wdata_r   <= ls_wdata_n;
            ic_buf_r     <= ic_buf_n;
            ic_data_r    <= ic_data_n;
            ls_buf_r     <= ls_buf_n;
            ls_rdata_r   <= ls_rdata_n;
            mem_a_r      <= mem_a_n;
            mem_dout_r   <= mem_dout_n;
            mem_wr_r     <= mem_wr_n;
            ic_data_en_r <= ic_data_en_n;
            ls_done_r    <= ls_done_n;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-addressed RAM model, directed cases
// and randomized fetch/load/store traffic checked against a behavioural model.
module tb_mem_ctrl;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    mem_ctrl_if bus();

    mem_ctrl dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    logic [7:0]  ram [0:65535];
    logic        fill_en   = 1'b0;
    logic        poke_en   = 1'b0;
    logic [15:0] poke_addr = 16'd0;
    logic [7:0]  poke_data = 8'd0;
    int          wr_cnt    = 0;
    int          io_wr_cnt = 0;
    logic [7:0]  io_last   = 8'd0;
    int          checks    = 0;
    int          errors    = 0;

    assign bus.mem_din = ram[bus.mem_a[15:0]];

    // RAM model: read data follows mem_a; writes land on the clock edge.
    always @(posedge clk_in) begin
        if (fill_en) begin
            for (int i = 0; i < 65536; i++) ram[i] <= 8'($urandom);
        end else if (poke_en) begin
            ram[poke_addr] <= poke_data;
        end else if (bus.mem_wr) begin
            if (bus.mem_a[17:16] == 2'b11) begin
                io_wr_cnt <= io_wr_cnt + 1;
                io_last   <= bus.mem_dout;
            end else begin
                ram[bus.mem_a[15:0]] <= bus.mem_dout;
                wr_cnt               <= wr_cnt + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [15:0] addr, input logic [7:0] data);
        poke_en = 1'b1; poke_addr = addr; poke_data = data;
        @(posedge clk_in); #1;
        poke_en = 1'b0;
    endtask

    task automatic pulse_ls(input logic wr, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        bus.LS_query_en = 1'b1; bus.LS_wr = wr; bus.LS_size = size;
        bus.LS_addr = addr; bus.LS_wdata = wdata;
        @(posedge clk_in); #1;
        bus.LS_query_en = 1'b0;
    endtask

    task automatic ic_txn(input logic [31:0] addr, input int pause_at, input int pause_len);
        logic [31:0]  base, a, hold;
        logic [127:0] exp;
        int act, tot, bad;
        bit done, paused;
        base = addr & 32'hFFFF_FFF0;
        for (int i = 0; i < 16; i++) begin
            a = base + 32'(i);
            exp[8*i +: 8] = ram[a[15:0]];
        end
        bus.IC_query_en = 1'b1; bus.IC_query_addr = addr;
        @(posedge clk_in); #1;
        bus.IC_query_en = 1'b0;
        act = 0; tot = 0; bad = 0; done = 1'b0; paused = 1'b0;
        if (bus.mem_a !== base) bad++;
        while (!done && tot < 300) begin
            if (act == pause_at && !paused) begin
                paused = 1'b1; hold = bus.mem_a; rdy_in = 1'b0;
                repeat (pause_len) begin
                    @(posedge clk_in); #1; tot++;
                    if (bus.mem_a !== hold || bus.IC_data_en !== 1'b0) bad++;
                end
                rdy_in = 1'b1;
            end
            @(posedge clk_in); #1; act++; tot++;
            if (act <= 15 && bus.mem_a !== base + 32'(act)) bad++;
            if (bus.IC_data_en === 1'b1) done = 1'b1;
        end
        check_eq("ic_done_seen", 128'(done), 128'd1);
        check_eq("ic_latency", 128'(act), 128'd17);
        check_eq("ic_data", bus.IC_data, exp);
        check_eq("ic_addr_seq", 128'(bad), 128'd0);
        check_eq("ic_mem_a_idle", 128'(bus.mem_a), 128'd0);
        @(posedge clk_in); #1;
        check_eq("ic_en_single", 128'(bus.IC_data_en), 128'd0);
        check_eq("ic_data_hold", bus.IC_data, exp);
    endtask

    task automatic ls_txn(input logic wr, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        int n, cyc, last_wr, wr_before;
        bit done;
        logic [31:0] a, exp, got, mask;
        logic [7:0]  beyond;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        mask = (n == 4) ? 32'hFFFF_FFFF : (n == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
        exp = 32'd0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            exp[8*i +: 8] = ram[a[15:0]];
        end
        a = addr + 32'(n);
        beyond = ram[a[15:0]];
        wr_before = wr_cnt;
        pulse_ls(wr, size, addr, wdata);
        cyc = 0; last_wr = -1; done = 1'b0;
        while (!done && cyc < 100) begin
            @(posedge clk_in); #1; cyc++;
            if (bus.mem_wr === 1'b1) last_wr = cyc;
            if (bus.LS_done === 1'b1) done = 1'b1;
        end
        check_eq("ls_done_seen", 128'(done), 128'd1);
        if (wr) begin
            got = 32'd0;
            for (int i = 0; i < n; i++) begin
                a = addr + 32'(i);
                got[8*i +: 8] = ram[a[15:0]];
            end
            a = addr + 32'(n);
            check_eq("st_data", 128'(got), 128'(wdata & mask));
            check_eq("st_no_overrun", 128'(ram[a[15:0]]), 128'(beyond));
            check_eq("st_write_count", 128'(wr_cnt - wr_before), 128'(n));
            check_eq("st_done_after_last", 128'(cyc), 128'(last_wr + 1));
        end else begin
            check_eq("ld_latency", 128'(cyc), 128'(n + 1));
            check_eq("ld_data", 128'(bus.LS_rdata), 128'(exp));
            @(posedge clk_in); #1;
            check_eq("ld_done_single", 128'(bus.LS_done), 128'd0);
            check_eq("ld_data_hold", 128'(bus.LS_rdata), 128'(exp));
        end
    endtask

    initial begin
        int cyc, ls_c, ic_c, early_wr, last_wr, io_before, activity;
        bit done;

        rst_in = 1'b1; rdy_in = 1'b1;
        bus.io_buffer_full = 1'b0; bus.IC_query_en = 1'b0; bus.IC_query_addr = 32'd0;
        bus.LS_query_en = 1'b0; bus.LS_wr = 1'b0; bus.LS_size = 2'd0;
        bus.LS_addr = 32'd0; bus.LS_wdata = 32'd0;
        fill_en = 1'b1;
        @(posedge clk_in); #1;
        fill_en = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        check_eq("rst_mem_a", 128'(bus.mem_a), 128'd0);
        check_eq("rst_mem_wr", 128'(bus.mem_wr), 128'd0);
        check_eq("rst_mem_dout", 128'(bus.mem_dout), 128'd0);
        check_eq("rst_ic_en", 128'(bus.IC_data_en), 128'd0);
        check_eq("rst_ic_data", bus.IC_data, 128'd0);
        check_eq("rst_ls_done", 128'(bus.LS_done), 128'd0);
        check_eq("rst_ls_rdata", 128'(bus.LS_rdata), 128'd0);
        rst_in = 1'b0;

        for (int i = 0; i < 16; i++) poke(16'h1000 + 16'(i), 8'(i));
        poke(16'h0020, 8'h78); poke(16'h0021, 8'h56);
        poke(16'h0022, 8'h34); poke(16'h0023, 8'h12);

        ic_txn(32'h0000_1004, -1, 0);
        check_eq("ic_ramp_const", bus.IC_data, 128'h0F0E0D0C0B0A09080706050403020100);
        ls_txn(1'b0, 2'd2, 32'h0000_0020, 32'd0);
        check_eq("ld_word_const", 128'(bus.LS_rdata), 128'h1234_5678);
        ls_txn(1'b0, 2'd0, 32'h0000_0022, 32'd0);
        check_eq("ld_byte_const", 128'(bus.LS_rdata), 128'h0000_0034);
        ls_txn(1'b1, 2'd1, 32'h0000_0041, 32'hAABB_CCDD);
        check_eq("st_half_41", 128'(ram[16'h0041]), 128'hDD);
        check_eq("st_half_42", 128'(ram[16'h0042]), 128'hCC);

        // Same-edge pulses from both clients.
        bus.LS_query_en = 1'b1; bus.LS_wr = 1'b0; bus.LS_size = 2'd2; bus.LS_addr = 32'h20;
        bus.IC_query_en = 1'b1; bus.IC_query_addr = 32'h0000_1008;
        @(posedge clk_in); #1;
        bus.LS_query_en = 1'b0; bus.IC_query_en = 1'b0;
        cyc = 0; ls_c = -1; ic_c = -1;
        while (ic_c < 0 && cyc < 100) begin
            @(posedge clk_in); #1; cyc++;
            if (bus.LS_done === 1'b1) ls_c = cyc;
            if (bus.IC_data_en === 1'b1) ic_c = cyc;
        end
        check_eq("arb_ls_first", 128'(ls_c), 128'd5);
        check_eq("arb_ic_after", 128'(ic_c), 128'd23);
        check_eq("arb_ls_data", 128'(bus.LS_rdata), 128'h1234_5678);
        check_eq("arb_ic_data", bus.IC_data, 128'h0F0E0D0C0B0A09080706050403020100);

        // IO byte store with the sink full for three edges.
        bus.io_buffer_full = 1'b1; io_before = io_wr_cnt;
        pulse_ls(1'b1, 2'd0, 32'h0003_0000, 32'h0000_005A);
        cyc = 0; early_wr = 0; last_wr = -1; done = 1'b0;
        while (!done && cyc < 50) begin
            @(posedge clk_in); #1; cyc++;
            if (cyc == 3) bus.io_buffer_full = 1'b0;
            if (bus.mem_wr === 1'b1) begin
                if (cyc <= 3) early_wr++;
                last_wr = cyc;
            end
            if (bus.LS_done === 1'b1) done = 1'b1;
        end
        check_eq("io_done_seen", 128'(done), 128'd1);
        check_eq("io_stall_no_wr", 128'(early_wr), 128'd0);
        check_eq("io_write_count", 128'(io_wr_cnt - io_before), 128'd1);
        check_eq("io_write_data", 128'(io_last), 128'h5A);
        check_eq("io_done_after", 128'(cyc), 128'(last_wr + 1));

        ic_txn(32'h0000_100C, 5, 4);
        check_eq("pause_ic_const", bus.IC_data, 128'h0F0E0D0C0B0A09080706050403020100);

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 2))
                0: ic_txn(32'($urandom_range(0, 32'hFFFF)), int'($urandom_range(0, 20)),
                          int'($urandom_range(0, 3)));
                1: ls_txn(1'b0, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 32'hFFFF)), 32'd0);
                default: ls_txn(1'b1, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 32'hFFFF)), $urandom);
            endcase
        end

        // Reset in the middle of a word store with an IC request pending.
        pulse_ls(1'b1, 2'd2, 32'h0000_0080, 32'h1122_3344);
        @(posedge clk_in); #1;
        bus.IC_query_en = 1'b1; bus.IC_query_addr = 32'h0000_2000;
        @(posedge clk_in); #1;
        bus.IC_query_en = 1'b0;
        rst_in = 1'b1;
        #1;
        check_eq("mid_rst_mem_a", 128'(bus.mem_a), 128'd0);
        check_eq("mid_rst_mem_wr", 128'(bus.mem_wr), 128'd0);
        check_eq("mid_rst_mem_dout", 128'(bus.mem_dout), 128'd0);
        check_eq("mid_rst_ls_done", 128'(bus.LS_done), 128'd0);
        check_eq("mid_rst_ic_en", 128'(bus.IC_data_en), 128'd0);
        check_eq("mid_rst_ic_data", bus.IC_data, 128'd0);
        check_eq("mid_rst_ls_rdata", 128'(bus.LS_rdata), 128'd0);
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        activity = 0;
        repeat (25) begin
            @(posedge clk_in); #1;
            if (bus.LS_done !== 1'b0 || bus.IC_data_en !== 1'b0 ||
                bus.mem_wr !== 1'b0 || bus.mem_a !== 32'd0) activity++;
        end
        check_eq("post_rst_quiet", 128'(activity), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
